// File: rtl/guess_input_cond_if.sv
// Button/tick bus between the raw-button pins, the conditioning stage and the
// guessing-game FSM.
interface guess_input_cond_if;
    logic [3:0] btn_raw;
    logic [3:0] b;
    logic [3:0] b_press;
    logic       b_any;
    logic       en;

    modport master (output btn_raw, input b, b_press, b_any, en);
    modport slave  (input btn_raw, output b, b_press, b_any, en);
endinterface

// File: rtl/guess_input_cond.sv
// Input conditioning for the guessing game: per-button sync + debounce with
// press pulses, plus the free-running step enable that paces the LED rotation.
module guess_input_cond_lane #(
    parameter int DB_CYCLES = 4,
    parameter int CW        = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic press,
    output logic lvl_nxt
);
    typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} db_state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    db_state_t       state;
    logic            s1, s2;
    logic [CW-1:0]   cnt;
    logic            done;

    assign done = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= LOW;
            cnt   <= '0;
            lvl   <= 1'b0;
            press <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= 1'b0;
            case (state)
                LOW: if (s2) begin
                    state <= WAIT_HI;
                    cnt   <= '0;
                end
                WAIT_HI: begin
                    if (!s2) state <= LOW;
                    else if (done) begin
                        state <= HIGH;
                        lvl   <= 1'b1;
                        press <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
                HIGH: if (!s2) begin
                    state <= WAIT_LO;
                    cnt   <= '0;
                end
                WAIT_LO: begin
                    if (s2) state <= HIGH;
                    else if (done) begin
                        state <= LOW;
                        lvl   <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= LOW;
            endcase
        end
    end

    // Next-cycle level, so b_any can be registered in step with b.
    always_comb begin
        lvl_nxt = lvl;
        if (state == WAIT_HI && s2 && done)  lvl_nxt = 1'b1;
        if (state == WAIT_LO && !s2 && done) lvl_nxt = 1'b0;
    end
endmodule

module guess_input_cond #(
    parameter int DB_CYCLES = 4,
    parameter int TICK_DIV  = 8
) (
    input  logic               clk,
    input  logic               rst,
    guess_input_cond_if.slave  bus
);
    localparam int NUM_LANES = 4;
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [NUM_LANES-1:0] lvl, press, lvl_nxt;
    logic                 any_q;
    logic [TW-1:0]        tick_cnt;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        guess_input_cond_lane #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .raw     (bus.btn_raw[i]),
            .lvl     (lvl[i]),
            .press   (press[i]),
            .lvl_nxt (lvl_nxt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)                        tick_cnt <= '0;
        else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
        else                            tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) any_q <= 1'b0;
        else     any_q <= |lvl_nxt;
    end

    assign bus.b       = lvl;
    assign bus.b_press = press;
    assign bus.b_any   = any_q;
    assign bus.en      = (tick_cnt == TICK_LAST);
endmodule

// File: tb/tb_guess_input_cond.sv
// Directed bench: stimulus pushes expected output events into queues; a negedge
// monitor pops and compares whenever b/b_press change or en pulses.
module tb_guess_input_cond;
    localparam int DB  = 4;
    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    guess_input_cond_if bus();

    guess_input_cond #(.DB_CYCLES(DB), .TICK_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int         cyc;
        logic [3:0] b;
        logic [3:0] p;
    } bev_t;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bev_t bq[$];
    int   tq[$];
    bit   mon_on = 1'b0;
    int   last_en = 0;
    logic [3:0] prev_b = '0;
    logic [3:0] prev_p = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endfunction

    task automatic expect_ev(input int c, input logic [3:0] b, input logic [3:0] p);
        bev_t e;
        e.cyc = c;
        e.b   = b;
        e.p   = p;
        bq.push_back(e);
    endtask

    always @(negedge clk) begin
        bev_t e;
        int   t;
        if (mon_on) begin
            if (bus.b !== prev_b || bus.b_press !== prev_p) begin
                if (bq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event at cycle %0d: b=%b b_press=%b", cyc, bus.b, bus.b_press);
                end else begin
                    e = bq.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("b", int'(bus.b), int'(e.b));
                    chk("b_press", int'(bus.b_press), int'(e.p));
                    chk("b_any", int'(bus.b_any), int'(|e.b));
                end
            end
            prev_b = bus.b;
            prev_p = bus.b_press;
            if (bus.en) begin
                if (tq.size() != 0) begin
                    t = tq.pop_front();
                    chk("en_cycle", cyc, t);
                end else begin
                    chk("en_period", cyc - last_en, DIV);
                end
                last_en = cyc;
            end
        end
    end

    initial begin
        int c;
        int r;
        bus.btn_raw = 4'b0000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        // three reset edges taken; last one is R
        r = cyc;
        rst = 1'b0;
        chk("rst_b", int'(bus.b), 0);
        chk("rst_b_press", int'(bus.b_press), 0);
        chk("rst_b_any", int'(bus.b_any), 0);
        chk("rst_en", int'(bus.en), 0);
        tq.push_back(r + 7);
        tq.push_back(r + 15);
        tq.push_back(r + 23);
        mon_on = 1'b1;
        repeat (4) @(negedge clk);

        // clean press and release of bit 0
        c = cyc; bus.btn_raw = 4'b0001;
        expect_ev(c + 7, 4'b0001, 4'b0001);
        expect_ev(c + 8, 4'b0001, 4'b0000);
        repeat (12) @(negedge clk);
        c = cyc; bus.btn_raw = 4'b0000;
        expect_ev(c + 7, 4'b0000, 4'b0000);
        repeat (12) @(negedge clk);

        // 3-cycle glitch on bit 1: no event expected
        bus.btn_raw = 4'b0010;
        repeat (3) @(negedge clk);
        bus.btn_raw = 4'b0000;
        repeat (12) @(negedge clk);

        // bouncy press on bit 2: 1,0,1,1,...
        bus.btn_raw = 4'b0100;
        @(negedge clk); bus.btn_raw = 4'b0000;
        @(negedge clk); bus.btn_raw = 4'b0100; c = cyc;
        expect_ev(c + 7, 4'b0100, 4'b0100);
        expect_ev(c + 8, 4'b0100, 4'b0000);
        repeat (12) @(negedge clk);
        c = cyc; bus.btn_raw = 4'b0000;
        expect_ev(c + 7, 4'b0000, 4'b0000);
        repeat (12) @(negedge clk);

        // simultaneous press of bits 3 and 2, then release bit 3 alone
        c = cyc; bus.btn_raw = 4'b1100;
        expect_ev(c + 7, 4'b1100, 4'b1100);
        expect_ev(c + 8, 4'b1100, 4'b0000);
        repeat (12) @(negedge clk);
        c = cyc; bus.btn_raw = 4'b0100;
        expect_ev(c + 7, 4'b0100, 4'b0000);
        repeat (12) @(negedge clk);
        c = cyc; bus.btn_raw = 4'b0000;
        expect_ev(c + 7, 4'b0000, 4'b0000);
        repeat (12) @(negedge clk);

        // reset while bit 0 sits in WAIT_HI with cnt=2, button kept held
        c = cyc; bus.btn_raw = 4'b0001;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        r = cyc;
        rst = 1'b0;
        chk("midrst_b", int'(bus.b), 0);
        chk("midrst_en", int'(bus.en), 0);
        tq.push_back(r + 7);
        tq.push_back(r + 15);
        tq.push_back(r + 23);
        expect_ev(r + 7, 4'b0001, 4'b0001);
        expect_ev(r + 8, 4'b0001, 4'b0000);
        repeat (30) @(negedge clk);
        c = cyc; bus.btn_raw = 4'b0000;
        expect_ev(c + 7, 4'b0000, 4'b0000);
        repeat (40) @(negedge clk);

        chk("btn_queue_drained", bq.size(), 0);
        chk("tick_queue_drained", tq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/guess_input_cond.md
# guess_input_cond

Input-conditioning stage that sits directly upstream of the guessing-game FSM. It synchronizes and debounces the four raw player buttons into the clean level bus `b[3:0]` the FSM consumes, and adds one-cycle press pulses. It also generates the periodic step-enable `en` that paces the FSM's LED rotation.

## Interface
- `DB_CYCLES`, default 4: consecutive synchronized cycles a button must hold a new level before it is accepted; ≥1. Board build uses 1_000_000.
- `TICK_DIV`, default 8: period of `en` in clock cycles; ≥2. Board build uses 25_000_000.

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  4  asynchronous, bouncy push-buttons; bit i = button i.
- `b`  out  4  debounced button levels, registered; feeds FSM `b`.
- `b_press`  out  4  one-cycle pulse per bit on accepted 0→1 of `b[i]`.
- `b_any`  out  1  OR of `b`, registered with `b`.
- `en`  out  1  one-cycle step enable every `TICK_DIV` cycles; feeds FSM `en`.

## Operation
- Per bit: 2-flop synchronizer (`s1`, `s2`), then independent 4-state debouncer with its own counter; width `max(1,$clog2(DB_CYCLES))`.
- Debouncer states: `LOW`, `WAIT_HI`, `HIGH`, `WAIT_LO`.
  - `LOW`: `s2`=1 → `WAIT_HI`, cnt←0.
  - `WAIT_HI`: `s2`=0 → `LOW` (glitch rejected). `s2`=1 and cnt==DB_CYCLES-1 → `HIGH`, `b[i]`←1, `b_press[i]`←1. Otherwise cnt←cnt+1.
  - `HIGH`: `s2`=0 → `WAIT_LO`, cnt←0.
  - `WAIT_LO`: symmetric to `WAIT_HI`. On acceptance → `LOW`, `b[i]`←0; no pulse on release.
- `b_press[i]` is registered, high exactly the cycle `b[i]` first reads 1; 0 at all other times.
- Tick generator: counter 0..TICK_DIV-1, wraps to 0. `en` = (counter==TICK_DIV-1), decoded from the counter register. `en` runs freely, independent of button activity.
- Bits are fully independent; simultaneous edges on several bits resolve in the same cycle.

## Timing
- Reset (rst high at an edge): `s1`,`s2`←0, all debouncers←`LOW`, counters←0, tick counter←0; `b`=0, `b_press`=0, `b_any`=0, `en`=0.
- Press latency: `btn_raw[i]` rises and is held from before edge E. Then `s2`=1 after E+1, `WAIT_HI` after E+2, and `b[i]`/`b_press[i]` high after edge E+2+DB_CYCLES.
- Release latency is identical: `b[i]` falls after E+2+DB_CYCLES.
- Rejection: any `s2` pulse shorter than DB_CYCLES+1 cycles produces no change on `b`.
- A bounce mid-wait returns the bit to its stable state, and the count restarts on the next edge.
- `en`: reset at edge R → `en` high after edge R+TICK_DIV-1, low after R+TICK_DIV. Repeats every TICK_DIV cycles and is never high two cycles in a row.
- Reset mid-debounce or mid-tick: operation is abandoned immediately. A button still held after reset is re-qualified from scratch, with full latency.
- A button held through reset: `b`=0 during reset, then rises at full latency after release.

## Test plan
- Reset/tick (DB=4, DIV=8): hold rst 3 cycles then release at edge R → all outputs 0; `en` high only after edges R+7, R+15, R+23.
- Clean press: `btn_raw`=0001 held from before edge E → `b`=0001 and `b_press`=0001 after E+6; `b_press`=0 after E+7; `b_any`=1.
- Glitch: `btn_raw[1]` high for 3 cycles, then low → `b`, `b_press` remain 0 throughout.
- Bouncy press: `btn_raw[2]` 1,0,1,1,1,1,1… → `b[2]` rises 6 edges after the final stable rise; exactly one `b_press[2]` pulse.
- Simultaneous: `btn_raw` 0000→1100 at one edge → `b_press`=1100 in a single cycle. Later release of 1000 only → `b`=0100 six edges later, no pulse.
- Reset mid-wait: assert rst while bit 0 is in `WAIT_HI` with cnt=2, keeping `btn_raw[0]` high → `b[0]`=0. It rises 6 edges after the reset-release edge, and the tick restarts.
